// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter with a small write FIFO.
// Define UART_TX_PARITY_EN to append an even-parity bit after the data bits.
`timescale 1ns/1ps
module uart_tx #(
  parameter real SYSCLOCK   = 27.0,
  parameter real BAUDRATE   = 1.0,
  parameter int  FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       fifo_full,
  output logic       tx_bsy,
  output logic       tx_done,
  output logic       tx
);

  localparam int CLKPERBIT = int'(SYSCLOCK / BAUDRATE);
  localparam int CW = $clog2(CLKPERBIT) + 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST = CW'(CLKPERBIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shift;
`ifdef UART_TX_PARITY_EN
  logic          par;
`endif

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          empty;
  logic          push;
  logic          pop;
  logic          last;
  logic [7:0]    head;

  assign empty     = (wr_ptr == rd_ptr);
  assign fifo_full = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                     (wr_ptr[AW] != rd_ptr[AW]);
  assign head      = mem[rd_ptr[AW-1:0]];

  always_comb begin
    last = (cnt == LAST);
    push = data_valid && !fifo_full;
    pop  = 1'b0;
    if (!empty)
      pop = (state == IDLE) || ((state == STOP) && last);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= data_in;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Line outputs are registered from the current state, so tx trails state by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      shift   <= '0;
      tx      <= 1'b1;
      tx_bsy  <= 1'b0;
      tx_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      tx_done <= (state == STOP) && last;
      tx_bsy  <= (state != IDLE) || !empty;
      if (state != IDLE)
        cnt <= last ? '0 : cnt + CW'(1);
      unique case (state)
        IDLE: begin
          tx  <= 1'b1;
          cnt <= '0;
          if (pop)
            state <= START;
        end
        START: begin
          tx <= 1'b0;
          if (last) begin
            state <= DATA;
            idx   <= '0;
          end
        end
        DATA: begin
          tx <= shift[0];
          if (last) begin
            shift <= {1'b0, shift[7:1]};
            idx   <= idx + 3'd1;
            if (idx == 3'd7)
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          tx <= par;
          if (last)
            state <= STOP;
        end
`endif
        STOP: begin
          tx <= 1'b1;
          if (last)
            state <= pop ? START : IDLE;
        end
        default: state <= IDLE;
      endcase
      if (pop) begin
        shift <= head;
`ifdef UART_TX_PARITY_EN
        par   <= ^head;
`endif
      end
    end
  end

endmodule
